// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes, flag bit positions and FSM states.
package alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W-1:0] OP_NEG = 4'd1;
  localparam logic [OP_W-1:0] OP_AND = 4'd2;
  localparam logic [OP_W-1:0] OP_XOR = 4'd3;
  localparam logic [OP_W-1:0] OP_SUB = 4'd4;
  localparam logic [OP_W-1:0] OP_SRL = 4'd5;
  localparam logic [OP_W-1:0] OP_SLL = 4'd6;
  localparam logic [OP_W-1:0] OP_SRA = 4'd7;
  localparam logic [OP_W-1:0] OP_MUL = 4'd8;
  localparam logic [OP_W-1:0] OP_OR  = 4'd9;

  localparam int FLAG_V = 3;
  localparam int FLAG_S = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]      cnt_reg;
  logic [WIDTH-1:0]   mcand_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic               done_reg;
  logic [WIDTH:0]     sum;

  // Upper half accumulates the multiplicand; the lower half holds the unconsumed multiplier bits.
  always_comb begin
    sum = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, mcand_reg} : {(WIDTH+1){1'b0}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      mcand_reg <= '0;
      acc_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start && cnt_reg == '0) begin
        mcand_reg <= a;
        acc_reg   <= {{WIDTH{1'b0}}, b};
        cnt_reg   <= CW'(WIDTH);
      end else if (cnt_reg != '0) begin
        acc_reg <= {sum, acc_reg[WIDTH-1:1]};
        cnt_reg <= cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) begin
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign busy    = (cnt_reg != '0);
  assign done    = done_reg;
  assign product = acc_reg;

endmodule

// File: rtl/alu_mc.sv
// Registered multi-cycle ALU with valid/ready on both sides; MUL runs on the iterative multiplier.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flag
);

  localparam int LOGW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [OP_W-1:0]    op_reg;
  logic [WIDTH-1:0]   result_reg;
  logic [3:0]         flag_reg;
  logic               out_valid_reg;
  logic               in_ready_reg;

  logic               is_mul_in;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic               is_sub;
  logic [WIDTH-1:0]   b_add;
  logic [WIDTH:0]     add_sum;
  logic [LOGW-1:0]    shamt;
  logic               shift_big;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic [3:0]         alu_flag;

  assign is_mul_in = MUL_EN && (op == OP_MUL);
  assign mul_start = (state_reg == ST_IDLE) && in_valid && is_mul_in;

  generate
    if (MUL_EN) begin : g_mul
      alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
      );
    end else begin : g_no_mul
      assign mul_busy    = 1'b0;
      assign mul_done    = 1'b0;
      assign mul_product = '0;
    end
  endgenerate

  // ADD and SUB share one WIDTH+1-bit adder; SUB feeds ~b with a carry-in of one.
  always_comb begin
    is_sub    = (op_reg == OP_SUB);
    b_add     = is_sub ? ~b_reg : b_reg;
    add_sum   = {1'b0, a_reg} + {1'b0, b_add} + {{WIDTH{1'b0}}, is_sub};
    shamt     = b_reg[LOGW-1:0];
    shift_big = |b_reg[WIDTH-1:LOGW];
    alu_res   = a_reg;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    case (op_reg)
      OP_ADD, OP_SUB: begin
        alu_res = add_sum[WIDTH-1:0];
        alu_c   = is_sub ? ~add_sum[WIDTH] : add_sum[WIDTH];
        alu_v   = (a_reg[WIDTH-1] == b_add[WIDTH-1]) && (add_sum[WIDTH-1] != a_reg[WIDTH-1]);
      end
      OP_NEG: begin
        alu_res = ~b_reg + WIDTH'(1);
        alu_v   = (b_reg == MIN_INT);
      end
      OP_AND: alu_res = a_reg & b_reg;
      OP_XOR: alu_res = a_reg ^ b_reg;
      OP_OR:  alu_res = a_reg | b_reg;
      OP_SRL: alu_res = shift_big ? '0 : (a_reg >> shamt);
      OP_SLL: alu_res = shift_big ? '0 : (a_reg << shamt);
      OP_SRA: alu_res = shift_big ? {WIDTH{a_reg[WIDTH-1]}} : WIDTH'($signed(a_reg) >>> shamt);
      OP_MUL: begin
        if (MUL_EN) begin
          alu_res = mul_product[WIDTH-1:0];
          alu_c   = |mul_product[2*WIDTH-1:WIDTH];
        end
      end
      default: alu_res = a_reg;
    endcase
    alu_flag         = 4'b0000;
    alu_flag[FLAG_V] = alu_v;
    alu_flag[FLAG_S] = alu_res[WIDTH-1];
    alu_flag[FLAG_Z] = (alu_res == '0);
    alu_flag[FLAG_C] = alu_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      op_reg        <= '0;
      result_reg    <= '0;
      flag_reg      <= '0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            a_reg        <= a;
            b_reg        <= b;
            op_reg       <= op;
            in_ready_reg <= 1'b0;
            state_reg    <= is_mul_in ? ST_BUSY : ST_DONE;
          end
        end
        ST_BUSY: begin
          if (mul_done && !mul_busy) begin
            result_reg    <= alu_res;
            flag_reg      <= alu_flag;
            out_valid_reg <= 1'b1;
            state_reg     <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Single-cycle ops spend their first DONE cycle evaluating the captured operands.
          if (!out_valid_reg) begin
            result_reg    <= alu_res;
            flag_reg      <= alu_flag;
            out_valid_reg <= 1'b1;
          end else if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          state_reg     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign flag      = flag_reg;

endmodule
